// File: rtl/mux_rr_scheduler_pkg.sv
// Shared widths, FSM encoding and the rotating priority search used by the
// round-robin scheduler and its 4:1 datapath mux.
package mux_rr_scheduler_pkg;

  localparam int MUX_W = 4;
  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set index of v when scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // Returns ptr when v is empty; callers qualify with |v.
  function automatic logic [1:0] first_idx(input logic [N_REQ-1:0] v,
                                           input logic [1:0] ptr);
    logic [1:0] idx;
    first_idx = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (v[idx]) first_idx = idx;
    end
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Requester-side and output-channel signals of the round-robin scheduler.
interface mux_rr_scheduler_if;
  import mux_rr_scheduler_pkg::*;

  logic [N_REQ-1:0] req;
  logic [MUX_W-1:0] i0, i1, i2, i3;
  logic [MUX_W-1:0] y;
  // A word transfers on a rising clk edge where y_valid and y_ready are both
  // high; y_valid never depends on y_ready, and ack marks that transfer.
  logic             y_valid;
  logic             y_ready;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] ack;
  logic             s0, s1;
  logic             busy;

  modport master (
    input  req, i0, i1, i2, i3, y_ready,
    output y, y_valid, gnt, ack, s0, s1, busy
  );

  modport slave (
    output req, i0, i1, i2, i3, y_ready,
    input  y, y_valid, gnt, ack, s0, s1, busy
  );

endinterface

// File: rtl/mux_rr_scheduler_mux4to1.sv
// Existing 4:1 word mux; select index is {s1,s0}.
module mux4to1
  import mux_rr_scheduler_pkg::*;
(
  input  logic [MUX_W-1:0] i0,
  input  logic [MUX_W-1:0] i1,
  input  logic [MUX_W-1:0] i2,
  input  logic [MUX_W-1:0] i3,
  input  logic             s0,
  input  logic             s1,
  output logic [MUX_W-1:0] y
);

  always_comb begin
    case ({s1, s0})
      2'b00:   y = i0;
      2'b01:   y = i1;
      2'b10:   y = i2;
      default: y = i3;
    endcase
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin arbiter that owns the mux selects: grants one requester for up
// to MAX_BURST accepted words, then rotates priority to the next index.
module mux_rr_scheduler
  import mux_rr_scheduler_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  mux_rr_scheduler_if.master  bus,
  output state_t              dbg_state
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       g;
  logic [3:0]       cnt;
  logic [N_REQ-1:0] gnt_q;
  logic             busy_q;

  logic             req_g;
  logic             accept;
  logic             last_word;
  logic             release_g;
  logic [1:0]       ptr_rot;
  logic [N_REQ-1:0] others;
  logic [1:0]       pick_idle;
  logic [1:0]       pick_rot;
  logic [MUX_W-1:0] y_mux;

  always_comb begin
    req_g     = bus.req[g];
    accept    = busy_q & req_g & bus.y_ready;
    last_word = accept & ((cnt + 4'd1) == BURST_LIM);
    release_g = busy_q & (last_word | ~req_g);
    ptr_rot   = g + 2'd1;
    others    = bus.req & ~(4'b0001 << g);
    pick_idle = first_idx(bus.req, ptr);
    pick_rot  = first_idx(others, ptr_rot);
  end

  // g doubles as the registered mux select and keeps its value while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= 2'd0;
      g      <= 2'd0;
      cnt    <= 4'd0;
      gnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state  <= GRANT;
            g      <= pick_idle;
            gnt_q  <= 4'b0001 << pick_idle;
            busy_q <= 1'b1;
            cnt    <= 4'd0;
          end
        end
        GRANT: begin
          if (release_g) begin
            ptr <= ptr_rot;
            cnt <= 4'd0;
            if (|others) begin
              g     <= pick_rot;
              gnt_q <= 4'b0001 << pick_rot;
            end else if (!req_g) begin
              state  <= IDLE;
              gnt_q  <= '0;
              busy_q <= 1'b0;
            end
          end else if (accept && cnt != BURST_LIM) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mux4to1 u_mux (
    .i0 (bus.i0),
    .i1 (bus.i1),
    .i2 (bus.i2),
    .i3 (bus.i3),
    .s0 (g[0]),
    .s1 (g[1]),
    .y  (y_mux)
  );

  assign bus.y       = y_mux;
  assign bus.y_valid = busy_q & req_g;
  assign bus.ack     = gnt_q & {N_REQ{accept}};
  assign bus.gnt     = gnt_q;
  assign bus.s0      = g[0];
  assign bus.s1      = g[1];
  assign bus.busy    = busy_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: directed scenarios on MAX_BURST=1 and 4
// instances, then random traffic checked against a request-level model.
module tb_mux_rr_scheduler;
  import mux_rr_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       rdy;
  logic [3:0] d[4];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mux_rr_scheduler_if bus1();
  mux_rr_scheduler_if bus4();
  state_t st1, st4;

  assign bus1.req = req;  assign bus4.req = req;
  assign bus1.y_ready = rdy;  assign bus4.y_ready = rdy;
  assign bus1.i0 = d[0];  assign bus4.i0 = d[0];
  assign bus1.i1 = d[1];  assign bus4.i1 = d[1];
  assign bus1.i2 = d[2];  assign bus4.i2 = d[2];
  assign bus1.i3 = d[3];  assign bus4.i3 = d[3];

  mux_rr_scheduler #(.MAX_BURST(1)) u_b1 (.clk(clk), .reset(reset), .bus(bus1), .dbg_state(st1));
  mux_rr_scheduler #(.MAX_BURST(4)) u_b4 (.clk(clk), .reset(reset), .bus(bus4), .dbg_state(st4));

  // Reference model: owner index (-1 when idle), priority pointer, words taken.
  int m_owner[2];
  int m_ptr[2];
  int m_cnt[2];
  int m_sel[2];
  int mb[2] = '{1, 4};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_data(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] e);
    d[0] = a; d[1] = b; d[2] = c; d[3] = e;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    rdy = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic int search(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_owner[j] = -1; m_ptr[j] = 0; m_cnt[j] = 0; m_sel[j] = 0;
    end
  endtask

  task automatic model_step(input int j);
    int o;
    int c;
    logic acc;
    logic [3:0] oth;
    o = m_owner[j];
    if (o < 0) begin
      if (req != 4'b0000) begin
        o = search(req, m_ptr[j]);
        m_cnt[j] = 0;
      end
    end else begin
      acc = req[o] && rdy;
      c = m_cnt[j] + (acc ? 1 : 0);
      if ((acc && c == mb[j]) || !req[o]) begin
        m_ptr[j] = (o + 1) % 4;
        m_cnt[j] = 0;
        oth = req;
        oth[o] = 1'b0;
        if (oth != 4'b0000) o = search(oth, m_ptr[j]);
        else if (!req[o]) o = -1;
      end else begin
        m_cnt[j] = c;
      end
    end
    m_owner[j] = o;
    if (o >= 0) m_sel[j] = o;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    set_data(4'd1, 4'd5, 4'd6, 4'd7);
    reset = 1'b1;
    req = 4'b0000;
    rdy = 1'b0;
    tick();
    samp();
    obs = {bus4.gnt, bus4.y_valid, bus4.s1, bus4.s0, bus4.busy, bus4.y};
    checks++;
    if (obs !== {4'b0000, 1'b0, 2'b00, 1'b0, 4'd1}) begin
      errors++; $display("FAIL reset_b4 gnt/yv/s/busy/y got %h want %h", obs, {4'b0000, 4'b0000, 4'd1});
    end
    obs = {bus1.gnt, bus1.y_valid, bus1.s1, bus1.s0, bus1.busy, bus1.y};
    checks++;
    if (obs !== {4'b0000, 1'b0, 2'b00, 1'b0, 4'd1}) begin
      errors++; $display("FAIL reset_b1 gnt/yv/s/busy/y got %h want %h", obs, {4'b0000, 4'b0000, 4'd1});
    end
    tick();
    reset = 1'b0;
    req = 4'b0100;
    tick();
    samp();
    obs = {bus4.gnt, bus4.y_valid, bus4.s1, bus4.s0, bus4.busy, bus4.y};
    checks++;
    if (obs !== {4'b0100, 1'b1, 2'b10, 1'b1, 4'd6} || st4 !== GRANT) begin
      errors++; $display("FAIL grant_latency gnt/yv/s/busy/y got %h want %h", obs, {4'b0100, 4'b1101, 4'd6});
    end
    // Asynchronous reset mid-burst, well away from any clock edge.
    #2 reset = 1'b1;
    #1;
    obs = {bus4.gnt, bus4.y_valid, bus4.s1, bus4.s0, bus4.busy, bus4.y};
    checks++;
    if (obs !== {4'b0000, 1'b0, 2'b00, 1'b0, 4'd1} || bus4.ack !== 4'b0000 || st4 !== IDLE) begin
      errors++; $display("FAIL async_reset gnt/yv/s/busy/y got %h want %h", obs, {4'b0000, 4'b0000, 4'd1});
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_rr_burst1();
    logic [3:0] ey[4];
    logic [3:0] eg;
    logic [11:0] obs;
    ey = '{4'd1, 4'd2, 4'd2, 4'd3};
    do_reset();
    set_data(4'd1, 4'd2, 4'd2, 4'd3);
    req = 4'b1111;
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      samp();
      eg = 4'b0001 << (i % 4);
      obs = {bus1.gnt, bus1.y, bus1.ack};
      checks++;
      if (obs !== {eg, ey[i % 4], eg}) begin
        errors++; $display("FAIL rr_burst1[%0d] gnt/y/ack got %h want %h", i, obs, {eg, ey[i % 4], eg});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [12:0] obs;
    do_reset();
    set_data(4'd1, 4'd2, 4'd2, 4'd3);
    req = 4'b0100;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      samp();
      obs = {bus4.gnt, bus4.y_valid, bus4.y, bus4.ack};
      checks++;
      if (obs !== {4'b0100, 1'b1, 4'd2, 4'b0000}) begin
        errors++; $display("FAIL backpressure[%0d] gnt/yv/y/ack got %h want %h", i, obs, {4'b0100, 1'b1, 4'd2, 4'b0000});
      end
    end
    tick();
    rdy = 1'b1;
    samp();
    obs = {bus4.gnt, bus4.y_valid, bus4.y, bus4.ack};
    checks++;
    if (obs !== {4'b0100, 1'b1, 4'd2, 4'b0100}) begin
      errors++; $display("FAIL bp_release gnt/yv/y/ack got %h want %h", obs, {4'b0100, 1'b1, 4'd2, 4'b0100});
    end
    tick();
    req = 4'b0000;
    samp();
    checks++;
    if (bus4.ack !== 4'b0000 || bus4.y_valid !== 1'b0) begin
      errors++; $display("FAIL bp_single_ack ack got %b want 0000", bus4.ack);
    end
  endtask

  task automatic test_burst4();
    logic [3:0] eg;
    logic [3:0] ey;
    logic [11:0] obs;
    do_reset();
    set_data(4'd1, 4'd2, 4'd2, 4'd3);
    req = 4'b0101;
    rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      samp();
      eg = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0100;
      ey = ((i / 4) % 2 == 0) ? 4'd1 : 4'd2;
      obs = {bus4.gnt, bus4.ack, bus4.y};
      checks++;
      if (obs !== {eg, eg, ey}) begin
        errors++; $display("FAIL burst4[%0d] gnt/ack/y got %h want %h", i, obs, {eg, eg, ey});
      end
    end
  endtask

  task automatic test_single_requester();
    logic [12:0] obs;
    do_reset();
    set_data(4'd1, 4'd2, 4'd2, 4'd3);
    req = 4'b1000;
    rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      samp();
      obs = {bus4.gnt, bus4.ack, bus4.busy, bus4.y};
      checks++;
      if (obs !== {4'b1000, 4'b1000, 1'b1, 4'd3}) begin
        errors++; $display("FAIL single_req[%0d] gnt/ack/busy/y got %h want %h", i, obs, {4'b1000, 4'b1000, 1'b1, 4'd3});
      end
    end
  endtask

  task automatic test_early_drop();
    logic [8:0] obs;
    logic [10:0] obs2;
    do_reset();
    set_data(4'd1, 4'd2, 4'd2, 4'd3);
    req = 4'b1010;
    tick();
    samp();
    obs = {bus4.gnt, bus4.y_valid, bus4.ack};
    checks++;
    if (obs !== {4'b0010, 1'b1, 4'b0000}) begin
      errors++; $display("FAIL drop_grant gnt/yv/ack got %h want %h", obs, {4'b0010, 1'b1, 4'b0000});
    end
    tick();
    req = 4'b1001;
    samp();
    obs = {bus4.gnt, bus4.y_valid, bus4.ack};
    checks++;
    if (obs !== {4'b0010, 1'b0, 4'b0000}) begin
      errors++; $display("FAIL drop_same_cycle gnt/yv/ack got %h want %h", obs, {4'b0010, 1'b0, 4'b0000});
    end
    tick();
    samp();
    obs2 = {bus4.gnt, bus4.s1, bus4.s0, bus4.y, bus4.y_valid};
    checks++;
    if (obs2 !== {4'b1000, 2'b11, 4'd3, 1'b1}) begin
      errors++; $display("FAIL drop_regrant gnt/s/y/yv got %h want %h", obs2, {4'b1000, 2'b11, 4'd3, 1'b1});
    end
  endtask

  task automatic test_random();
    logic [15:0] obs;
    logic [15:0] expv;
    logic [3:0]  eg;
    logic [1:0]  es;
    logic        eyv;
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      tick();
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) d[k] = 4'($urandom_range(0, 15));
      samp();
      for (int j = 0; j < 2; j++) begin
        eg  = (m_owner[j] < 0) ? 4'b0000 : 4'(1 << m_owner[j]);
        eyv = (m_owner[j] >= 0) && req[m_owner[j]];
        es  = 2'(m_sel[j]);
        expv = {eg, eyv, d[m_sel[j]], (eyv && rdy) ? eg : 4'b0000, es, m_owner[j] >= 0};
        if (j == 0) obs = {bus1.gnt, bus1.y_valid, bus1.y, bus1.ack, bus1.s1, bus1.s0, bus1.busy};
        else        obs = {bus4.gnt, bus4.y_valid, bus4.y, bus4.ack, bus4.s1, bus4.s0, bus4.busy};
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL random[%0d] burst=%0d gnt/yv/y/ack/s/busy got %h want %h", n, mb[j], obs, expv);
        end
        model_step(j);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req = 4'b0000;
    rdy = 1'b0;
    set_data(4'd1, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_rr_burst1();
    test_backpressure();
    test_burst4();
    test_single_requester();
    test_early_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
